pipe_addsub: RTL and testbench

//  - Parametrised, pipelined N-bit adder/subtractor; successor to the fixed 8-bit ripple adder.
//  - Splits the operand into SEG_W-bit segments with one register stage per segment.
//  - Carry ripples between segments across clock edges.
//  - Valid/ready handshake on both sides; sits between the operand source and the fnd_controller/result sink.

---
 rtl/pipe_addsub_if.sv | 27 ++
 rtl/pipe_addsub.sv | 98 +++++++++
 tb/tb_pipe_addsub.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result bundle for pipe_addsub: source-side handshake plus sink-side handshake.
// master = operand source and result sink; slave = the adder pipeline.
interface pipe_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented pipelined add/sub, latency WIDTH/SEG_W, full rate; whole pipe stalls when the output is held.
// Optional output saturation on signed overflow: define PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input logic         clk,
  input logic         reset,
  pipe_addsub_if.slave io
);
  localparam int STAGES = WIDTH / SEG_W;

  logic             advance;
  logic [WIDTH-1:0] b_x;
  logic             c_x;
  logic             ovf_nx;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_raw;

  assign advance     = ~io.out_valid | io.out_ready;
  assign io.in_ready = advance;

  // Subtract becomes a + ~b + ~cin, folded in before the first stage.
  assign b_x = io.sub ? ~io.b : io.b;
  assign c_x = io.sub ? ~io.cin : io.cin;

  // Stage word layout: {remaining b segments, rotating a/result word}.
  // The a word rotates right by one segment per stage while each finished
  // result segment enters at the top, so after STAGES rotations it is the sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int IN_W  = 2*WIDTH - k*SEG_W;
    localparam int OUT_W = IN_W - SEG_W;

    logic [IN_W-1:0]  w_in;
    logic             c_in;
    logic             v_in;
    logic [SEG_W:0]   seg;
    logic [WIDTH-1:0] a_rot;
    logic [OUT_W-1:0] w_q;
    logic             c_q;
    logic             vld_q;

    if (k == 0) begin : g_head
      assign w_in = {b_x, io.a};
      assign c_in = c_x;
      assign v_in = io.in_valid;
    end else begin : g_body
      assign w_in = g_stg[k-1].w_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].vld_q;
    end

    assign seg   = {1'b0, w_in[SEG_W-1:0]} + {1'b0, w_in[WIDTH +: SEG_W]}
                 + (SEG_W+1)'(c_in);
    assign a_rot = (w_in[WIDTH-1:0] >> SEG_W)
                 | (WIDTH'(seg[SEG_W-1:0]) << (WIDTH - SEG_W));

    if (k == STAGES-1) begin : g_tail
      // Carry into the MSB recovered as a ^ b ^ sum at that bit.
      assign ovf_nx = w_in[SEG_W-1] ^ w_in[WIDTH+SEG_W-1] ^ seg[SEG_W-1] ^ seg[SEG_W];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        w_q   <= '0;
        c_q   <= 1'b0;
        vld_q <= 1'b0;
      end else if (advance) begin
        w_q   <= OUT_W'({w_in[IN_W-1:WIDTH] >> SEG_W, a_rot});
        c_q   <= seg[SEG_W];
        vld_q <= v_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_nx;
    end
  end

  assign sum_raw      = g_stg[STAGES-1].w_q;
  assign io.cout      = g_stg[STAGES-1].c_q;
  assign io.out_valid = g_stg[STAGES-1].vld_q;
  assign io.ovf       = ovf_q;

`ifdef PIPE_ADDSUB_SAT_EN
  // Raw MSB set on overflow means the true result was positive.
  logic [WIDTH-1:0] sat_val;
  assign sat_val = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
  assign io.sum  = ovf_q ? sat_val : sum_raw;
`else
  assign io.sum  = sum_raw;
`endif
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: 8/4 main instance plus 16/16 and 16/2 parameter points.
module tb_pipe_addsub;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(8))  m  ();
  pipe_addsub_if #(.WIDTH(16)) w1 ();
  pipe_addsub_if #(.WIDTH(16)) w8 ();

  pipe_addsub #(.WIDTH(8),  .SEG_W(4))  u_dut8   (.clk(clk), .reset(reset), .io(m));
  pipe_addsub #(.WIDTH(16), .SEG_W(16)) u_dut16a (.clk(clk), .reset(reset), .io(w1));
  pipe_addsub #(.WIDTH(16), .SEG_W(2))  u_dut16b (.clk(clk), .reset(reset), .io(w8));

`ifdef PIPE_ADDSUB_SAT_EN
  localparam logic [7:0]  E_ADD_OVF = 8'h7F;
  localparam logic [7:0]  E_SUB_OVF = 8'h80;
  localparam logic [15:0] E_W1_SUM  = 16'h7FFF;
`else
  localparam logic [7:0]  E_ADD_OVF = 8'h96;
  localparam logic [7:0]  E_SUB_OVF = 8'h7F;
  localparam logic [15:0] E_W1_SUM  = 16'h8000;
`endif

  int nchk  = 0;
  int npass = 0;
  int lat;
  logic [7:0] got_q[$];
  logic [7:0] exp_bp [4] = '{8'h02, 8'h04, 8'h06, 8'h08};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_out8(output int l);
    l = 1;
    while (!m.out_valid && l < 12) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb,
                      input logic [7:0] es, input logic ec, input logic eo);
    int l;
    @(negedge clk);
    m.a = a; m.b = b; m.cin = ci; m.sub = sb; m.in_valid = 1'b1;
    #1 chk({tag, "_rdy"}, m.in_ready, 1);
    @(negedge clk);
    m.in_valid = 1'b0;
    wait_out8(l);
    chk({tag, "_lat"},  l, 2);
    chk({tag, "_sum"},  m.sum, es);
    chk({tag, "_cout"}, m.cout, ec);
    chk({tag, "_ovf"},  m.ovf, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx, stall, seen;
    reset = 1'b0;
    m.in_valid = 0;  m.a = '0;  m.b = '0;  m.cin = 0;  m.sub = 0;  m.out_ready = 1;
    w1.in_valid = 0; w1.a = '0; w1.b = '0; w1.cin = 0; w1.sub = 0; w1.out_ready = 1;
    w8.in_valid = 0; w8.a = '0; w8.b = '0; w8.cin = 0; w8.sub = 0; w8.out_ready = 1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_vld",  m.out_valid, 0);
    chk("rst_sum",  m.sum, 0);
    chk("rst_cout", m.cout, 0);
    chk("rst_ovf",  m.ovf, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rdy", m.in_ready, 1);
    chk("rel_vld", m.out_valid, 0);

    run8("add_ovf",  8'h3C, 8'h5A, 0, 0, E_ADD_OVF, 0, 1);
    run8("carry",    8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    run8("carry_ci", 8'hFF, 8'h01, 1, 0, 8'h01, 1, 0);
    run8("sub_brw",  8'h10, 8'h20, 0, 1, 8'hF0, 0, 0);
    run8("sub_ovf",  8'h80, 8'h01, 0, 1, E_SUB_OVF, 1, 1);
    run8("all_ones", 8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0);
    run8("sub_bin",  8'h05, 8'h03, 1, 1, 8'h01, 1, 0);

    // Back-to-back ops with a two-cycle output stall once the first result shows.
    idx = 0; stall = 0; seen = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (m.out_valid && seen == 0) begin
        seen  = 1;
        stall = 2;
      end
      m.out_ready = (stall == 0);
      m.cin = 0; m.sub = 0;
      if (idx < 4) begin
        m.in_valid = 1'b1;
        m.a = 8'(idx + 1);
        m.b = 8'(idx + 1);
      end else begin
        m.in_valid = 1'b0;
      end
      #1;
      if (stall > 0) begin
        chk("bp_stall_rdy", m.in_ready, 0);
        chk("bp_stall_sum", m.sum, 8'h02);
        stall--;
      end
      if (m.out_valid && m.out_ready) got_q.push_back(m.sum);
      if (m.in_valid && m.in_ready) idx++;
    end
    m.out_ready = 1'b1;
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_res%0d", i), (i < got_q.size()) ? got_q[i] : 8'hXX, exp_bp[i]);

    // Reset with two operations in flight.
    @(negedge clk);
    m.a = 8'h07; m.b = 8'h07; m.in_valid = 1'b1;
    @(negedge clk);
    m.a = 8'h09; m.b = 8'h09;
    @(negedge clk);
    m.in_valid = 1'b0;
    chk("mr_pre_vld", m.out_valid, 1);
    chk("mr_pre_sum", m.sum, 8'h0E);
    #2 reset = 1'b0;
    #1;
    chk("mr_vld", m.out_valid, 0);
    chk("mr_sum", m.sum, 0);
    chk("mr_ovf", m.ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mr_rel_rdy", m.in_ready, 1);
    @(negedge clk);
    chk("mr_no_stale", m.out_valid, 0);
    run8("mr_new", 8'h05, 8'h06, 0, 0, 8'h0B, 0, 0);

    // Single-stage instance.
    @(negedge clk);
    w1.a = 16'h7FFF; w1.b = 16'h0001; w1.in_valid = 1'b1;
    @(negedge clk);
    w1.in_valid = 1'b0;
    lat = 1;
    while (!w1.out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("w1_lat",  lat, 1);
    chk("w1_sum",  w1.sum, E_W1_SUM);
    chk("w1_ovf",  w1.ovf, 1);
    chk("w1_cout", w1.cout, 0);

    // Eight-stage instance.
    @(negedge clk);
    w8.a = 16'hFFFF; w8.b = 16'h0001; w8.in_valid = 1'b1;
    @(negedge clk);
    w8.in_valid = 1'b0;
    lat = 1;
    while (!w8.out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("w8_lat",  lat, 8);
    chk("w8_sum",  w8.sum, 16'h0000);
    chk("w8_cout", w8.cout, 1);
    chk("w8_ovf",  w8.ovf, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
